// File: rtl/spi_pkg.sv
// Shared SPI definitions: transmit FSM states, default word width and
// chip-select polarity (the receive side uses the same constant).
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOADED = 2'd1,
      SHIFT  = 2'd2
   } tx_state_t;

   localparam int   SPI_WORD_W = 8;
   localparam logic CS_ACTIVE  = 1'b0;

endpackage

// File: rtl/spi_tx_shiftreg.sv
// Loadable WIDTH-bit transmit shift register with clear, load and shift enable.
// Priority: clear > load > shift.
// Build option: SPI_TX_LSB_FIRST_EN selects LSB-first (shift right, serial bit = q[0]);
// otherwise MSB-first (shift left, serial bit = q[WIDTH-1]). Both fill with zeros.
// ser_d_o is the serial bit of the value the register takes at the next edge,
// so the parent can register miso in step with the register contents.
module spi_tx_shiftreg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             shift_i,
   output logic             ser_d_o
);

   logic [WIDTH-1:0] shreg_q;
   logic [WIDTH-1:0] shreg_d;

   // Next register value: clear, parallel load, directional shift or hold.
   always_comb begin
      shreg_d = shreg_q;
      if (clr_i) begin
         shreg_d = '0;
      end else if (load_i) begin
         shreg_d = data_i;
      end else if (shift_i) begin
`ifdef SPI_TX_LSB_FIRST_EN
         shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
`else
         shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
`endif
      end else begin
         shreg_d = shreg_q;
      end
   end

   // Serial bit that will be presented once shreg_d is registered.
   always_comb begin
`ifdef SPI_TX_LSB_FIRST_EN
      ser_d_o = shreg_d[0];
`else
      ser_d_o = shreg_d[WIDTH-1];
`endif
   end

   // Register the shift contents; synchronous active-low reset clears it.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         shreg_q <= '0;
      end else begin
         shreg_q <= shreg_d;
      end
   end

endmodule

// File: rtl/spi_miso_transmitter.sv
// SPI mode-0 peripheral transmit path. A loaded word is shifted out on miso,
// one bit per conditioned SCLK falling-edge pulse, while chip select is active.
// miso_oe drives the pad tristate; miso is forced to 0 whenever miso_oe is 0.
// All outputs are registered. Build option: SPI_TX_LSB_FIRST_EN (LSB first).
module spi_miso_transmitter
   import spi_pkg::*;
#(
   parameter int WIDTH = SPI_WORD_W,
   parameter int CNTW  = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             sclk_negedge,
   input  logic             cs_n,
   input  logic             load,
   input  logic [WIDTH-1:0] parallel_in,
   output logic             miso,
   output logic             miso_oe,
   output logic             busy,
   output logic             done,
   output logic             aborted
);

   tx_state_t        state_q, state_d;
   logic [CNTW-1:0]  bitcnt_q, bitcnt_d;
   logic             done_q, done_d;
   logic             aborted_q, aborted_d;
   logic             miso_q, miso_d;
   logic             miso_oe_q, miso_oe_d;
   logic             busy_q, busy_d;
   logic             sh_clr_s, sh_load_s, sh_shift_s;
   logic             ser_d_s;
   logic             last_edge_s;

   // The completing edge wins over a simultaneous chip-select rise.
   assign last_edge_s = sclk_negedge && (bitcnt_q == CNTW'(WIDTH - 1));

   spi_tx_shiftreg #(
      .WIDTH (WIDTH)
   ) u_shiftreg (
      .clk     (clk),
      .reset_n (reset_n),
      .clr_i   (sh_clr_s),
      .load_i  (sh_load_s),
      .data_i  (parallel_in),
      .shift_i (sh_shift_s),
      .ser_d_o (ser_d_s)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (load) begin
               state_d = LOADED;
            end else begin
               state_d = IDLE;
            end
         end
         LOADED: begin
            if (cs_n == CS_ACTIVE) begin
               state_d = SHIFT;
            end else begin
               state_d = LOADED;
            end
         end
         SHIFT: begin
            if (last_edge_s) begin
               state_d = IDLE;
            end else if (cs_n != CS_ACTIVE) begin
               state_d = IDLE;
            end else begin
               state_d = SHIFT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Datapath controls, bit counter and strobes for the current state.
   always_comb begin
      sh_clr_s   = 1'b0;
      sh_load_s  = 1'b0;
      sh_shift_s = 1'b0;
      bitcnt_d   = bitcnt_q;
      done_d     = 1'b0;
      aborted_d  = 1'b0;
      case (state_q)
         IDLE, LOADED: begin
            sh_load_s = load;
            bitcnt_d  = '0;
         end
         SHIFT: begin
            if (last_edge_s) begin
               sh_shift_s = 1'b1;
               done_d     = 1'b1;
               bitcnt_d   = '0;
            end else if (cs_n != CS_ACTIVE) begin
               sh_clr_s   = 1'b1;
               aborted_d  = 1'b1;
               bitcnt_d   = '0;
            end else if (sclk_negedge) begin
               sh_shift_s = 1'b1;
               bitcnt_d   = bitcnt_q + CNTW'(1);
            end else begin
               bitcnt_d   = bitcnt_q;
            end
         end
         default: begin
            sh_clr_s = 1'b1;
            bitcnt_d = '0;
         end
      endcase
   end

   // Pad-side outputs follow the state being entered, so they line up with it.
   always_comb begin
      miso_oe_d = (state_d == SHIFT);
      busy_d    = (state_d != IDLE);
      if (miso_oe_d) begin
         miso_d = ser_d_s;
      end else begin
         miso_d = 1'b0;
      end
   end

   // Counter and output registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         bitcnt_q  <= '0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         miso_q    <= 1'b0;
         miso_oe_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         bitcnt_q  <= bitcnt_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
         miso_q    <= miso_d;
         miso_oe_q <= miso_oe_d;
         busy_q    <= busy_d;
      end
   end

   assign miso    = miso_q;
   assign miso_oe = miso_oe_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign aborted = aborted_q;

endmodule

// File: tb/tb_spi_miso_transmitter.sv
// Directed self-checking bench for spi_miso_transmitter (WIDTH=8).
// Inputs change and outputs are sampled 1 ns after each rising clock edge.
module tb_spi_miso_transmitter;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       sclk_negedge;
   logic       cs_n;
   logic       load;
   logic [7:0] parallel_in;
   logic       miso;
   logic       miso_oe;
   logic       busy;
   logic       done;
   logic       aborted;

   int checks = 0;
   int errors = 0;

   spi_miso_transmitter #(.WIDTH(8), .CNTW(3)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .sclk_negedge (sclk_negedge),
      .cs_n         (cs_n),
      .load         (load),
      .parallel_in  (parallel_in),
      .miso         (miso),
      .miso_oe      (miso_oe),
      .busy         (busy),
      .done         (done),
      .aborted      (aborted)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Bit i (0 = first transmitted) of word w for the current build.
   function automatic logic exp_bit(input logic [7:0] w, input int i);
`ifdef SPI_TX_LSB_FIRST_EN
      return w[i];
`else
      return w[7-i];
`endif
   endfunction

   // Load a word from IDLE and start the frame; leaves the DUT in SHIFT.
   task automatic start_word(input logic [7:0] w);
      load = 1'b1; parallel_in = w;
      tick();
      load = 1'b0; cs_n = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      reset_n = 1'b0; sclk_negedge = 1'b0; cs_n = 1'b1; load = 1'b0; parallel_in = 8'h00;
      repeat (2) tick();
      checks++;
      if ({miso, miso_oe, busy, done, aborted} !== 5'b00000) begin
         errors++;
         $display("FAIL reset_outputs: got miso,oe,busy,done,aborted=%b required 00000",
                  {miso, miso_oe, busy, done, aborted});
      end
      reset_n = 1'b1;
      tick();
      // cs_n and sclk pulses are ignored in IDLE
      cs_n = 1'b0; sclk_negedge = 1'b1;
      tick();
      sclk_negedge = 1'b0; cs_n = 1'b1;
      checks++;
      if ({miso_oe, busy} !== 2'b00) begin
         errors++;
         $display("FAIL idle_ignores: got oe,busy=%b required 00", {miso_oe, busy});
      end
   endtask

   // Shift a whole word with pulses 4 clk apart, checking every bit and the finish.
   task automatic shift_full(input logic [7:0] w, input string tag, input logic load_mid);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (miso !== exp_bit(w, i) || miso_oe !== 1'b1) begin
            errors++;
            $display("FAIL %s_bit%0d: got miso=%b oe=%b required miso=%b oe=1",
                     tag, i, miso, miso_oe, exp_bit(w, i));
         end
         sclk_negedge = 1'b1;
         tick();
         sclk_negedge = 1'b0;
         if (i < 7) begin
            checks++;
            if (done !== 1'b0 || busy !== 1'b1) begin
               errors++;
               $display("FAIL %s_mid%0d: got done=%b busy=%b required done=0 busy=1",
                        tag, i, done, busy);
            end
         end else begin
            checks++;
            if ({done, aborted, miso_oe, miso, busy} !== 5'b10000) begin
               errors++;
               $display("FAIL %s_done: got done,aborted,oe,miso,busy=%b required 10000",
                        tag, {done, aborted, miso_oe, miso, busy});
            end
         end
         if (load_mid && i == 1) begin
            load = 1'b1; parallel_in = 8'h00;
         end
         tick();
         load = 1'b0;
         tick();
         tick();
      end
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL %s_done_width: got done=%b required 0", tag, done);
      end
      cs_n = 1'b1;
   endtask

   task automatic test_nominal();
      load = 1'b1; parallel_in = 8'hA5;
      tick();
      load = 1'b0;
      checks++;
      if ({busy, miso_oe} !== 2'b10) begin
         errors++;
         $display("FAIL loaded_state: got busy,oe=%b required 10", {busy, miso_oe});
      end
      cs_n = 1'b0;
      tick();
      shift_full(8'hA5, "nominal", 1'b0);
   endtask

   task automatic test_abort();
      start_word(8'hFF);
      for (int i = 0; i < 3; i++) begin
         sclk_negedge = 1'b1;
         tick();
         sclk_negedge = 1'b0;
         tick();
      end
      checks++;
      if (miso !== 1'b1 || miso_oe !== 1'b1) begin
         errors++;
         $display("FAIL abort_pre: got miso=%b oe=%b required 1 1", miso, miso_oe);
      end
      cs_n = 1'b1;
      tick();
      checks++;
      if ({aborted, done, miso_oe, busy, miso} !== 5'b10000) begin
         errors++;
         $display("FAIL abort_pulse: got aborted,done,oe,busy,miso=%b required 10000",
                  {aborted, done, miso_oe, busy, miso});
      end
      tick();
      checks++;
      if ({aborted, done} !== 2'b00) begin
         errors++;
         $display("FAIL abort_width: got aborted,done=%b required 00", {aborted, done});
      end
   endtask

   task automatic test_collision();
      start_word(8'hA5);
      for (int i = 0; i < 7; i++) begin
         sclk_negedge = 1'b1;
         tick();
         sclk_negedge = 1'b0;
         tick();
      end
      checks++;
      if (miso !== exp_bit(8'hA5, 7)) begin
         errors++;
         $display("FAIL collide_last_bit: got %b required %b", miso, exp_bit(8'hA5, 7));
      end
      sclk_negedge = 1'b1; cs_n = 1'b1; load = 1'b1; parallel_in = 8'hFF;
      tick();
      sclk_negedge = 1'b0; load = 1'b0;
      checks++;
      if ({done, aborted, busy, miso_oe} !== 4'b1000) begin
         errors++;
         $display("FAIL collide: got done,aborted,busy,oe=%b required 1000",
                  {done, aborted, busy, miso_oe});
      end
      tick();
      checks++;
      if ({done, aborted, busy} !== 3'b000) begin
         errors++;
         $display("FAIL collide_after: got done,aborted,busy=%b required 000",
                  {done, aborted, busy});
      end
   endtask

   task automatic test_reload_ignore();
      load = 1'b1; parallel_in = 8'h11;
      tick();
      parallel_in = 8'h3C;
      tick();
      load = 1'b0; cs_n = 1'b0;
      tick();
      shift_full(8'h3C, "reload", 1'b1);
   endtask

   task automatic test_midword_reset();
      start_word(8'hA5);
      for (int i = 0; i < 2; i++) begin
         sclk_negedge = 1'b1;
         tick();
         sclk_negedge = 1'b0;
         tick();
      end
      checks++;
      if (busy !== 1'b1 || miso_oe !== 1'b1) begin
         errors++;
         $display("FAIL midreset_pre: got busy=%b oe=%b required 1 1", busy, miso_oe);
      end
      reset_n = 1'b0;
      tick();
      checks++;
      if ({miso, miso_oe, busy, done, aborted} !== 5'b00000) begin
         errors++;
         $display("FAIL midreset: got miso,oe,busy,done,aborted=%b required 00000",
                  {miso, miso_oe, busy, done, aborted});
      end
      reset_n = 1'b1;
      sclk_negedge = 1'b1;
      tick();
      sclk_negedge = 1'b0;
      checks++;
      if ({miso_oe, busy, done, aborted} !== 4'b0000) begin
         errors++;
         $display("FAIL midreset_idle: got oe,busy,done,aborted=%b required 0000",
                  {miso_oe, busy, done, aborted});
      end
      cs_n = 1'b1;
      // a fresh word after reset starts from bit 0 again
      start_word(8'h80);
      checks++;
      if (miso !== exp_bit(8'h80, 0) || miso_oe !== 1'b1) begin
         errors++;
         $display("FAIL midreset_restart: got miso=%b oe=%b required %b 1",
                  miso, miso_oe, exp_bit(8'h80, 0));
      end
      cs_n = 1'b1;
      tick();
      tick();
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_abort();
      test_collision();
      test_reload_ignore();
      test_midword_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
